mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 14 +
 rtl/mem_responder.sv | 69 ++++++
 tb/tb_mem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between an initiator and mem_responder
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, be, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed SRAM responder with fixed wait states and alignment/range errors
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  acc, bad, commit, c_we;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [31:0]           c_wdata;
  logic [3:0]            c_be;
  // With zero wait states the commit happens on the acceptance edge, so use the live bus
  always_comb begin
    acc     = state_q == IDLE && bus.req;
    bad     = |bus.addr[1:0] || |bus.addr[31:DEPTH_LOG2+2];
    commit  = (acc && !bad && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
    c_we    = acc ? bus.we : we_q;
    c_idx   = acc ? bus.addr[DEPTH_LOG2+1:2] : idx_q;
    c_wdata = acc ? bus.wdata : wdata_q;
    c_be    = acc ? bus.be : be_q;
  end
  // Memory shares the reset block only so that no write can commit while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (commit && c_we)
        for (int i = 0; i < 4; i++)
          if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      if (commit && !c_we) rdata_q <= mem[c_idx];
      case (state_q)
        IDLE: if (bus.req) begin
          we_q    <= bus.we;
          idx_q   <= bus.addr[DEPTH_LOG2+1:2];
          wdata_q <= bus.wdata;
          be_q    <= bus.be;
          cnt_q   <= 4'(WAIT_CYCLES - 1);
          state_q <= bad ? ERR : (WAIT_CYCLES == 0 ? RESP : WAIT);
        end
        WAIT: begin
          cnt_q   <= cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
          state_q <= cnt_q == 4'd0 ? RESP : WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.ready = state_q == RESP || state_q == ERR;
  assign bus.err   = state_q == ERR;
  assign bus.busy  = state_q != IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a word-array model
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [2][256];
  logic [31:0] rd_m [2];
  mem_responder_if bus ();
  mem_responder_if bus0 ();
  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit z, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if (z) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d; bus0.be = b;
    end else begin
      bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    end
  endtask

  task automatic access(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit bad, seen;
    int n, exp_n;
    logic [7:0] idx;
    logic [31:0] mask;
    bad = a[1:0] != 2'b00 || (a >> 10) != 0;
    exp_n = bad ? 1 : (z ? 1 : 3);
    idx = a[9:2];
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    if (!bad && w) mem_m[z][idx] = (mem_m[z][idx] & ~mask) | (d & mask);
    if (!bad && !w) rd_m[z] = mem_m[z][idx];
    @(negedge clk);
    drive(z, 1'b1, w, a, d, b);
    @(posedge clk);
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (z ? bus0.ready : bus.ready) seen = 1;
      else check("busy_in_wait", z ? bus0.busy : bus.busy, 1);
      drive(z, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
    check("ready_seen", 32'(seen), 1);
    check("latency", n, exp_n);
    check("err", z ? bus0.err : bus.err, 32'(bad));
    check("rdata", z ? bus0.rdata : bus.rdata, rd_m[z]);
    @(negedge clk);
    check("ready_one_cycle", z ? bus0.ready : bus.ready, 0);
    check("idle_after", z ? bus0.busy : bus.busy, 0);
    drive(z, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] a;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    rd_m[0] = 32'h0;
    rd_m[1] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rdata0", bus0.rdata, 0);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) access(0, 1, 32'(i) << 2, $urandom, 4'hF);
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 0, 32'h10, 32'h0, 4'h0);
    check("full_write_read", bus.rdata, 32'hDEADBEEF);
    access(0, 1, 32'h10, 32'h11223344, 4'b0101);
    access(0, 0, 32'h10, 32'h0, 4'h0);
    check("byte_enable_merge", bus.rdata, 32'hDE22BE44);
    access(0, 0, 32'h13, 32'h0, 4'h0);
    access(0, 1, 32'h400, 32'h55555555, 4'hF);
    access(0, 0, 32'h400, 32'h0, 4'h0);
    access(0, 1, 32'h14, 32'h0BADF00D, 4'h0);
    access(0, 0, 32'h14, 32'h0, 4'h0);
    access(0, 0, 32'h10, 32'h0, 4'h0);
    check("mem_after_errors", bus.rdata, 32'hDE22BE44);
    access(1, 1, 32'h10, 32'hCAFEF00D, 4'hF);
    access(1, 0, 32'h10, 32'h0, 4'h0);
    check("zero_wait_read", bus0.rdata, 32'hCAFEF00D);
    repeat (200) begin
      a = 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | (32'($urandom_range(1, 4194303)) << 10);
        default: ;
      endcase
      access(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    drive(0, 1, 0, 32'h10, 32'h0, 4'h0);
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      check("burst_ready", bus.ready, 32'(n % 4 == 3));
      check("burst_busy", bus.busy, 32'(n % 4 != 0));
      if (n % 4 == 3) check("burst_rdata", bus.rdata, mem_m[0][4]);
      if (n == 15) drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    end
    rd_m[0] = mem_m[0][4];
    access(0, 1, 32'h20, 32'h0, 4'hF);
    @(negedge clk);
    drive(0, 1, 1, 32'h20, 32'hFFFFFFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("busy_before_reset", bus.busy, 1);
    reset = 1'b0;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_rdata", bus.rdata, 0);
    rd_m[0] = 32'h0;
    rd_m[1] = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    access(0, 0, 32'h20, 32'h0, 4'h0);
    check("aborted_write", bus.rdata, 32'h0);
    access(1, 0, 32'h10, 32'h0, 4'h0);
    check("persist_zero_wait", bus0.rdata, 32'hCAFEF00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
